// File: rtl/div_const_seq_ctrl.sv
// Sequenced unsigned divide-by-constant using one shared radix-4 digit step per cycle.
// Optional build macro DIV_CONST_REM_OUT_EN adds the out_remainder port.
module div_const_seq_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIVISOR = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
`ifdef DIV_CONST_REM_OUT_EN
  output logic [3:0]       out_remainder,
`endif
  output logic             busy
);

  localparam int unsigned RW    = 4;
  localparam int unsigned TW    = RW + 2;
  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [TW-1:0] D1 = TW'(DIVISOR);
  localparam logic [TW-1:0] D2 = TW'(2 * DIVISOR);
  localparam logic [TW-1:0] D3 = TW'(3 * DIVISOR);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [RW-1:0]    rem;
  logic [CW-1:0]    cnt;
  logic             load, step;
  logic [TW-1:0]    t;
  logic [1:0]       q;
  logic [RW-1:0]    rem_nxt;

  // Digit step: t = 4*rem + next two dividend bits; quotient digit by compare/subtract.
  always_comb begin
    t       = {rem, shreg[WIDTH-1 -: 2]};
    q       = 2'd0;
    rem_nxt = RW'(t);
    if (t >= D3) begin
      q       = 2'd3;
      rem_nxt = RW'(t - D3);
    end else if (t >= D2) begin
      q       = 2'd2;
      rem_nxt = RW'(t - D2);
    end else if (t >= D1) begin
      q       = 2'd1;
      rem_nxt = RW'(t - D1);
    end
  end

  // Next-state logic; abort overrides every handshake.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
        BUSY: begin
          step = 1'b1;
          if (cnt == '0) state_nxt = DONE;
        end
        DONE: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == BUSY);
    end
  end

  // Dividend bits leave at the top while quotient digits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (load) begin
      shreg <= in_dividend;
      rem   <= '0;
      cnt   <= CW'(STEPS - 1);
    end else if (step) begin
      shreg <= {shreg[WIDTH-3:0], q};
      rem   <= rem_nxt;
      cnt   <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_quotient <= '0;
    end else if (step && cnt == '0) begin
      out_quotient <= {shreg[WIDTH-3:0], q};
    end
  end

`ifdef DIV_CONST_REM_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_remainder <= '0;
    end else if (step && cnt == '0) begin
      out_remainder <= rem_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_div_const_seq_ctrl.sv
// Scoreboard bench for div_const_seq_ctrl: directed latency/abort/backpressure cases plus random traffic.
module tb_div_const_seq_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DIV   = 11;
  localparam int unsigned STEPS = WIDTH / 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic             busy;
`ifdef DIV_CONST_REM_OUT_EN
  logic [3:0]       out_remainder;
`endif

  div_const_seq_ctrl #(.WIDTH(WIDTH), .DIVISOR(DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
`ifdef DIV_CONST_REM_OUT_EN
    .out_remainder(out_remainder),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int results = 0;
  int cycle   = 0;
  logic [63:0] sb[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] d);
    return {32'(d % DIV), 32'(d / DIV)};
  endfunction

  // Scoreboard monitor: push on accept, pop on result, drop on abort.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy || out_valid) check("in_ready_low", 32'(in_ready), 32'd0);
      if (abort) begin
        if ((busy || out_valid) && sb.size() > 0) void'(sb.pop_front());
      end else begin
        if (in_valid && in_ready) sb.push_back(model(in_dividend));
        if (out_valid && out_ready) begin
          check("sb_occupancy", 32'(sb.size()), 32'd1);
          if (sb.size() > 0) begin
            logic [63:0] e;
            e = sb.pop_front();
            check("quotient", out_quotient, e[31:0]);
`ifdef DIV_CONST_REM_OUT_EN
            check("remainder", 32'(out_remainder), e[63:32]);
`endif
            results++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, output int acc_cycle);
    logic a;
    logic ok;
    ok = 1'b0;
    acc_cycle = 0;
    in_valid = 1'b1;
    in_dividend = d;
    for (int i = 0; i < 100; i++) begin
      a = in_ready && !abort;
      tick();
      if (a) begin
        acc_cycle = cycle;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_quotient"}, out_quotient, 32'd0);
`ifdef DIV_CONST_REM_OUT_EN
    check({tag, "_remainder"}, 32'(out_remainder), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, lat;
    logic seen;
    logic [31:0] d;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_dividend = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Reset in the middle of BUSY, then a clean request.
    send(32'h12345678, a0);
    repeat (5) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(32'd1000000, a0);
    wait_valid(lat);
    check("q_1e6", out_quotient, 32'h0001631D);
`ifdef DIV_CONST_REM_OUT_EN
    check("r_1e6", 32'(out_remainder), 32'd1);
`endif
    release_result();

    // All-ones dividend and acceptance-to-result latency.
    send(32'hFFFFFFFF, a0);
    wait_valid(lat);
    check("latency", 32'(lat), 32'(STEPS));
    check("q_ones", out_quotient, 32'h1745D174);
`ifdef DIV_CONST_REM_OUT_EN
    check("r_ones", 32'(out_remainder), 32'd3);
`endif
    release_result();

    // Back-to-back with the consumer always ready.
    out_ready = 1'b1;
    send(32'd10, a0);
    send(32'd11, a1);
    send(32'd0, a2);
    check("issue_gap_1", 32'(a1 - a0), 32'(STEPS + 2));
    check("issue_gap_2", 32'(a2 - a1), 32'(STEPS + 2));
    wait_valid(lat);
    check("q_zero_latency", 32'(lat), 32'(STEPS));
    tick();
    out_ready = 1'b0;

    // Backpressure: result held, stray requests ignored.
    d = 32'hDEADBEEF;
    send(d, a0);
    wait_valid(lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2) == 0;
      in_dividend = $urandom;
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_quotient", out_quotient, d / DIV);
    end
    in_valid = 1'b0;
    release_result();

    // Abort at step 8; no result, then a re-issue completes normally.
    send(32'h12345678, a0);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_result", 32'(seen), 32'd0);
    send(32'h12345678, a0);
    wait_valid(lat);
    check("q_reissue", out_quotient, 32'h12345678 / DIV);
`ifdef DIV_CONST_REM_OUT_EN
    check("r_reissue", 32'(out_remainder), 32'h12345678 % DIV);
`endif
    release_result();

    // Abort in DONE together with out_ready drops the result but keeps the value.
    send(32'd100, a0);
    wait_valid(lat);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    check("done_abort_valid", 32'(out_valid), 32'd0);
    check("done_abort_hold", out_quotient, 32'd9);

    // Abort in IDLE together with in_valid: not accepted.
    in_valid = 1'b1;
    in_dividend = 32'd5;
    abort = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    tick();

    // Random traffic with gaps, backpressure and occasional aborts.
    for (int i = 0; i < 40000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       in_dividend = 32'd0;
        1:       in_dividend = 32'hFFFFFFFF;
        default: in_dividend = $urandom;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 299) == 0);
      tick();
    end
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    repeat (2 * STEPS + 8) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("results_seen", 32'(results > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
